enemy_datapath: RTL and testbench

//  Holds position/velocity state for N_ENEMY 5x5 enemy sprites and streams their pixels to the VGA plot mux.

---
 rtl/enemy_datapath.sv | 217 +++++++++++++++++++++
 tb/tb_enemy_datapath.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_datapath.sv
// ---------------------------------------------------------------------------
// enemy_datapath
//   Holds position and direction state for N_ENEMY square enemy sprites and
//   streams their pixels, one per enabled cycle, to the VGA plot mux. The game
//   control FSM moves every enemy with load_coord, walks the pixel sweep with
//   enemy_datapath_en and picks draw/erase with enemy_op. touch_edge reports
//   which enemies overlap the player sprite.
//
// Ports
//   clk                in   1        system clock
//   reset              in   1        synchronous, active-high reset
//   load_coord         in   1        step every enemy one move, restart sweep
//   enemy_datapath_en  in   1        advance the pixel sweep this cycle
//   enemy_op           in   2        00 = draw in COLOUR, others = erase (black)
//   self_x             in   8        player sprite top-left x
//   self_y             in   7        player sprite top-left y
//   x_out              out  8        pixel x
//   y_out              out  7        pixel y
//   colour_out         out  3        pixel colour
//   pix_valid          out  1        x/y/colour carry a new pixel this cycle
//   touch_edge         out  N_ENEMY  bit i = enemy i overlaps player sprite
//   sweep_done         out  1        pulse alongside the last pixel of a sweep
//
// Pixel stream: a pixel is produced one cycle after a cycle with
// enemy_datapath_en=1 and load_coord=0. pix_valid marks that cycle; there is
// no back-pressure, the consumer must take every valid pixel. Between valid
// pixels x/y/colour hold their last value.
// ---------------------------------------------------------------------------
module enemy_datapath #(
    parameter int         N_ENEMY = 10,
    parameter int         SPRITE  = 5,
    parameter int         X_MAX   = 160,
    parameter int         Y_MAX   = 120,
    parameter logic [2:0] COLOUR  = 3'b100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_coord,
    input  logic               enemy_datapath_en,
    input  logic [1:0]         enemy_op,
    input  logic [7:0]         self_x,
    input  logic [6:0]         self_y,
    output logic [7:0]         x_out,
    output logic [6:0]         y_out,
    output logic [2:0]         colour_out,
    output logic               pix_valid,
    output logic [N_ENEMY-1:0] touch_edge,
    output logic               sweep_done
);

    localparam int IDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam int PIX_W = (SPRITE > 1) ? $clog2(SPRITE) : 1;

    localparam logic [7:0]       X_LIM    = 8'(X_MAX - SPRITE);
    localparam logic [6:0]       Y_LIM    = 7'(Y_MAX - SPRITE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENEMY - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPRITE - 1);
    localparam logic signed [8:0] SPR_S   = 9'(SPRITE);

    // Enemy state. dxn/dyn = 1 means the enemy moves towards 0 on that axis.
    logic [7:0] ex_q  [N_ENEMY];
    logic [7:0] ex_d  [N_ENEMY];
    logic [6:0] ey_q  [N_ENEMY];
    logic [6:0] ey_d  [N_ENEMY];
    logic [N_ENEMY-1:0] dxn_q, dxn_d;
    logic [N_ENEMY-1:0] dyn_q, dyn_d;

    // Sweep counters.
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] col_q, col_d;

    // Output registers.
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         colour_q, colour_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [N_ENEMY-1:0] touch_q, touch_d;

    logic pix_fire;
    logic last_pix;

    // Overlap test on one axis. Operands are zero-extended to 9 bits and the
    // difference is treated as signed so no wrap-around can fake a hit.
    function automatic logic near(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < SPR_S) && (diff > -SPR_S);
    endfunction

    // Movement: each axis bounces off its edge by reversing and stepping
    // back inward in the same move, so an enemy never sits outside the legal
    // range for even one cycle.
    always_comb begin
        for (int i = 0; i < N_ENEMY; i++) begin
            ex_d[i]  = ex_q[i];
            ey_d[i]  = ey_q[i];
            dxn_d[i] = dxn_q[i];
            dyn_d[i] = dyn_q[i];
            if (load_coord) begin
                if (!dxn_q[i] && ex_q[i] == X_LIM) begin
                    dxn_d[i] = 1'b1;
                    ex_d[i]  = ex_q[i] - 8'd1;
                end else if (dxn_q[i] && ex_q[i] == 8'd0) begin
                    dxn_d[i] = 1'b0;
                    ex_d[i]  = 8'd1;
                end else if (dxn_q[i]) begin
                    ex_d[i]  = ex_q[i] - 8'd1;
                end else begin
                    ex_d[i]  = ex_q[i] + 8'd1;
                end

                if (!dyn_q[i] && ey_q[i] == Y_LIM) begin
                    dyn_d[i] = 1'b1;
                    ey_d[i]  = ey_q[i] - 7'd1;
                end else if (dyn_q[i] && ey_q[i] == 7'd0) begin
                    dyn_d[i] = 1'b0;
                    ey_d[i]  = 7'd1;
                end else if (dyn_q[i]) begin
                    ey_d[i]  = ey_q[i] - 7'd1;
                end else begin
                    ey_d[i]  = ey_q[i] + 7'd1;
                end
            end
        end
    end

    // Sweep counters: col is the fastest digit, idx the slowest. A move
    // restarts the sweep so the next draw starts at enemy 0's top-left.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        idx_d = idx_q;
        if (load_coord) begin
            col_d = '0;
            row_d = '0;
            idx_d = '0;
        end else if (enemy_datapath_en) begin
            if (col_q == PIX_LAST) begin
                col_d = '0;
                if (row_q == PIX_LAST) begin
                    row_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    row_d = row_q + PIX_W'(1);
                end
            end else begin
                col_d = col_q + PIX_W'(1);
            end
        end
    end

    assign pix_fire = enemy_datapath_en && !load_coord;
    assign last_pix = (idx_q == IDX_LAST) && (row_q == PIX_LAST) && (col_q == PIX_LAST);

    // Pixel outputs and collision flags.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        valid_d  = pix_fire;
        done_d   = pix_fire && last_pix;
        if (pix_fire) begin
            x_d      = ex_q[idx_q] + 8'(col_q);
            y_d      = ey_q[idx_q] + 7'(row_q);
            colour_d = (enemy_op == 2'b00) ? COLOUR : 3'b000;
        end
        for (int i = 0; i < N_ENEMY; i++) begin
            touch_d[i] = near(ex_q[i], self_x) && near({1'b0, ey_q[i]}, {1'b0, self_y});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                ex_q[i]  <= 8'(8 + 15 * i);
                ey_q[i]  <= 7'(10 + 8 * i);
                dxn_q[i] <= 1'(i % 2);
                dyn_q[i] <= 1'(i % 2);
            end
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            touch_q  <= '0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                ex_q[i] <= ex_d[i];
                ey_q[i] <= ey_d[i];
            end
            dxn_q    <= dxn_d;
            dyn_q    <= dyn_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            touch_q  <= touch_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_q;
    assign pix_valid  = valid_q;
    assign sweep_done = done_q;
    assign touch_edge = touch_q;

endmodule

// File: tb/tb_enemy_datapath.sv
// ---------------------------------------------------------------------------
// tb_enemy_datapath
//   Directed scenarios plus randomized traffic for enemy_datapath. A
//   behavioural model (integer positions, a flat pixel number decoded with
//   division) predicts every registered output; a compare process checks the
//   DUT each cycle, and a few literal values pin the model.
// ---------------------------------------------------------------------------
module tb_enemy_datapath;

    localparam int N  = 10;
    localparam int SP = 5;
    localparam int XM = 160;
    localparam int YM = 120;
    localparam int NPIX = N * SP * SP;

    typedef struct packed {
        logic [7:0]   x;
        logic [6:0]   y;
        logic [2:0]   col;
        logic         valid;
        logic         done;
        logic [N-1:0] touch;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_coord = 1'b0;
    logic         enemy_datapath_en = 1'b0;
    logic [1:0]   enemy_op = 2'b00;
    logic [7:0]   self_x = 8'd200;
    logic [6:0]   self_y = 7'd110;
    logic [7:0]   x_out;
    logic [6:0]   y_out;
    logic [2:0]   colour_out;
    logic         pix_valid;
    logic [N-1:0] touch_edge;
    logic         sweep_done;

    always #5 clk = ~clk;

    enemy_datapath dut (
        .clk               (clk),
        .reset             (reset),
        .load_coord        (load_coord),
        .enemy_datapath_en (enemy_datapath_en),
        .enemy_op          (enemy_op),
        .self_x            (self_x),
        .self_y            (self_y),
        .x_out             (x_out),
        .y_out             (y_out),
        .colour_out        (colour_out),
        .pix_valid         (pix_valid),
        .touch_edge        (touch_edge),
        .sweep_done        (sweep_done)
    );

    // ---------------- scoreboard state ----------------
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    exp_t last_e = '0;

    // ---------------- behavioural model ----------------
    int m_ex[N];
    int m_ey[N];
    int m_dx[N];
    int m_dy[N];
    int m_pix = 0;   // flat pixel number 0..NPIX-1 of the next pixel

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_ex[i] = 8 + 15 * i;
            m_ey[i] = 10 + 8 * i;
            m_dx[i] = (i % 2 == 0) ? 1 : -1;
            m_dy[i] = (i % 2 == 0) ? 1 : -1;
        end
        m_pix = 0;
    endfunction

    // One bounded axis step: turn around at the edge and step back inward.
    function automatic void axis_move(inout int p, inout int d, input int lim);
        if (d == 1 && p == lim) begin
            d = -1;
            p = lim - 1;
        end else if (d == -1 && p == 0) begin
            d = 1;
            p = 1;
        end else begin
            p = p + d;
        end
    endfunction

    // Predict the outputs that follow the inputs currently being driven.
    task automatic model_step();
        exp_t e;
        int   idx, rr, cc;
        e = last_e;
        e.valid = 1'b0;
        e.done  = 1'b0;
        if (reset) begin
            model_reset();
            e = '0;
        end else begin
            for (int i = 0; i < N; i++)
                e.touch[i] = (iabs(m_ex[i] - int'(self_x)) < SP) &&
                             (iabs(m_ey[i] - int'(self_y)) < SP);
            if (load_coord) begin
                for (int i = 0; i < N; i++) begin
                    axis_move(m_ex[i], m_dx[i], XM - SP);
                    axis_move(m_ey[i], m_dy[i], YM - SP);
                end
                m_pix = 0;
            end else if (enemy_datapath_en) begin
                idx = m_pix / (SP * SP);
                rr  = (m_pix % (SP * SP)) / SP;
                cc  = m_pix % SP;
                e.x     = 8'(m_ex[idx] + cc);
                e.y     = 7'(m_ey[idx] + rr);
                e.col   = (enemy_op == 2'b00) ? 3'b100 : 3'b000;
                e.valid = 1'b1;
                e.done  = (m_pix == NPIX - 1);
                m_pix   = (m_pix + 1) % NPIX;
            end
        end
        last_e = e;
        exp_q.push_back(e);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare process: every cycle that has a prediction queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("x_out", 32'(x_out), 32'(e.x));
                chk("y_out", 32'(y_out), 32'(e.y));
                chk("colour_out", 32'(colour_out), 32'(e.col));
                chk("pix_valid", 32'(pix_valid), 32'(e.valid));
                chk("sweep_done", 32'(sweep_done), 32'(e.done));
                chk("touch_edge", 32'(touch_edge), 32'(e.touch));
            end
        end
    end

    // ---------------- driver ----------------
    // Drive one cycle of inputs at the falling edge, record the prediction,
    // and return just after the compare process has run.
    task automatic step(input logic r, input logic ld, input logic en, input logic [1:0] op);
        @(negedge clk);
        reset             = r;
        load_coord        = ld;
        enemy_datapath_en = en;
        enemy_op          = op;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        int k;
        // Reset state.
        do_reset();
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_touch", 32'(touch_edge), 32'd0);

        // First pixels of a draw sweep, then the full sweep end.
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("p1_x", 32'(x_out), 32'd8);
        chk("p1_y", 32'(y_out), 32'd10);
        chk("p1_colour", 32'(colour_out), 32'd4);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("p2_x", 32'(x_out), 32'd9);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("p3_x", 32'(x_out), 32'd10);
        chk("p3_y", 32'(y_out), 32'd10);
        for (int i = 3; i < NPIX; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("last_done", 32'(sweep_done), 32'd1);
        chk("last_x", 32'(x_out), 32'd147);
        chk("last_y", 32'(y_out), 32'd86);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("wrap_x", 32'(x_out), 32'd8);
        chk("wrap_y", 32'(y_out), 32'd10);
        chk("wrap_done", 32'(sweep_done), 32'd0);

        // Right-edge bounce of enemy 0: 146 moves bring ex to 154.
        do_reset();
        for (int i = 0; i < 146; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("bounce_154", 32'(x_out), 32'd154);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("bounce_155", 32'(x_out), 32'd155);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("bounce_back_154", 32'(x_out), 32'd154);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("bounce_153", 32'(x_out), 32'd153);

        // Collision boundaries.
        do_reset();
        self_x = 8'd9;  self_y = 7'd12;
        step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("touch_hit", 32'(touch_edge), 32'd1);
        self_x = 8'd13; self_y = 7'd10;
        step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("touch_edge5", 32'(touch_edge), 32'd0);
        self_x = 8'd12; self_y = 7'd14;
        step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("touch_edge4", 32'(touch_edge), 32'd1);
        self_x = 8'd200; self_y = 7'd110;

        // Erase sweep.
        do_reset();
        for (int i = 0; i < NPIX; i++) begin
            step(1'b0, 1'b0, 1'b1, 2'b01);
            if (i == 0) chk("erase_colour", 32'(colour_out), 32'd0);
        end
        chk("erase_done", 32'(sweep_done), 32'd1);

        // Enable gap after pixel 30.
        do_reset();
        for (int i = 0; i <= 30; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00);
            chk("gap_valid", 32'(pix_valid), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("p31_x", 32'(x_out), 32'd24);
        chk("p31_y", 32'(y_out), 32'd19);

        // Reset mid-sweep.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b0, 1'b1, 2'b00);
        chk("midrst_x", 32'(x_out), 32'd0);
        chk("midrst_valid", 32'(pix_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("restart_x", 32'(x_out), 32'd8);
        chk("restart_y", 32'(y_out), 32'd10);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    k = $urandom_range(0, N - 1);
                    self_x = 8'(m_ex[k] + int'($urandom_range(0, 12)) - 6 < 0 ? 0 :
                                m_ex[k] + int'($urandom_range(0, 12)) - 6);
                    self_y = 7'(m_ey[k] + int'($urandom_range(0, 12)) - 6 < 0 ? 0 :
                                m_ey[k] + int'($urandom_range(0, 12)) - 6);
                end else begin
                    self_x = 8'($urandom_range(0, 255));
                    self_y = 7'($urandom_range(0, 127));
                end
            end
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 8),
                 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
